dmux1t8_32_buf: RTL
===================

// Module: dmux1t8_32_buf
// PURPOSE
//  1-to-8 32-bit distributor, the inverse of the 8-to-1 32-bit selector: one source stream fans out to 8 sinks.
//  Each output channel has a registered one-entry holding slot with valid/ready handshake.
//  Channel is picked by external select or by an internal round-robin pointer (auto mode).
//  Sits between a single producer (CPU/bus write port) and eight independent consumers.
// PARAMETERS
//  DW    32  data width per channel
//  N     8   number of output channels (fixed 8 in this release)
//  SELW  3   select width, = log2(N)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  mode_auto  in   1       1: use internal pointer; 0: use s
//  s          in   SELW    external channel select (ignored when mode_auto=1)
//  I          in   DW      input data
//  in_valid   in   1       producer offers I
//  in_ready   out  1       block accepts I this cycle
//  o          out  N*DW    channel k data on o[k*DW +: DW]
//  out_valid  out  N       bit k: slot k holds data
//  out_ready  in   N       bit k: consumer k takes data this cycle
//  cur_sel    out  SELW    channel targeted this cycle (s or pointer)
// BEHAVIOUR
//  - Reset (async, rst_n=0): every slot empty, o=0, out_valid=0, ptr=0, so cur_sel=s or 0. in_ready follows from empty slots.
//  - cur_sel = mode_auto ? ptr : s (combinational).
//  - in_ready = ~out_valid[cur_sel] | out_ready[cur_sel].
//    Combinational path out_ready -> in_ready is allowed.
//    No path from in_valid to in_ready.
//  - Accept = in_valid & in_ready.
//    On accept, slot[cur_sel] <= I and out_valid[cur_sel] <= 1 at next edge. Latency I -> o is 1 cycle.
//  - Drain k = out_valid[k] & out_ready[k].
//    Drain without refill clears out_valid[k] at next edge. o[k] holds its last value and is not zeroed.
//  - Drain and accept on the same slot in the same cycle: slot takes new I, out_valid[k] stays 1 (no bubble).
//  - Slots are independent: drains on any subset of channels can occur in the same cycle as an accept to another channel.
//  - Data is never overwritten while valid and not draining. in_ready=0 stalls the producer.
//  - Auto pointer: ptr <= ptr+1 mod N on each accept in auto mode (7 -> 0 wrap).
//    No advance when there is no accept. A stalled pointer waits on its full slot and does not skip it.
//  - Manual mode: ptr is frozen.
//    Switching mode_auto takes effect combinationally. ptr resumes from its held value.
//  - Reset asserted mid-transfer discards all held data. No partial state survives.
// STRUCTURE
//  - Shared package dmux_pkg: DW, N, SELW localparams and typedef logic [DW-1:0] word_t.
//  - Sub-module dmux_slot (one-entry buffer: data reg and valid flag, load/drain inputs), instantiated N times via generate.
//  - Top holds ptr, the cur_sel mux, the in_ready mux and the load decoder (one-hot of cur_sel gated by accept).
// TESTING
//  1. Reset: hold rst_n=0, drive in_valid=1 -> out_valid=8'h00, o=0, no load. Release -> in_ready=1.
//  2. Manual sweep: s=0..7, I=32'h55AA3333 + k*32'h1111 (equal to 32'h55AA3333, 32'h55AA4444, ... as k steps), out_ready=0 -> after 8 accepts out_valid=8'hFF, each o[k] holds its own word, in_ready=0.
//  3. Backpressure: slot 3 full, s=3, out_ready=0, I=32'hAA552222 -> in_ready=0 and o[3] unchanged. Set out_ready[3]=1 -> accept same cycle, o[3]=32'hAA552222 next edge, out_valid[3] stays 1.
//  4. Auto wrap: mode_auto=1, all out_ready=1, 10 back-to-back words -> cur_sel 0..7,0,1. Words 8 and 9 land in slots 0 and 1. Throughput is 1 word/clk.
//  5. Auto stall: mode_auto=1, ptr=5, slot 5 full, out_ready[5]=0 -> ptr stays 5 and in_ready=0. Release out_ready[5] -> next word goes to slot 5 and ptr becomes 6.
//  6. Async reset mid-stream: pull rst_n low between clock edges during test 4 -> outputs clear immediately (no wait for a clock edge), ptr=0.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared widths and types for the 1-to-8 buffered distributor.
package dmux_pkg;
  localparam int DW   = 32;
  localparam int N    = 8;
  localparam int SELW = 3;

  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/dmux_slot.sv
// One-entry holding slot: data register plus valid flag, loaded by the
// distributor and drained by its consumer.
module dmux_slot
  import dmux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  ready,
  input  word_t din,
  output word_t dout,
  output logic  valid
);

  logic drain;
  assign drain = valid & ready;

  // A load in the same cycle as a drain wins, so the slot never bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (load)       dout <= din;
      if (load)       valid <= 1'b1;
      else if (drain) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux1t8_32_buf.sv
// 1-to-8 32-bit distributor with per-channel one-entry slots; channel picked
// by external select or an accept-driven round-robin pointer.
module dmux1t8_32_buf
  import dmux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_auto,
  input  logic [SELW-1:0]   s,
  input  logic [DW-1:0]     I,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N*DW-1:0]   o,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [SELW-1:0]   cur_sel
);

  logic [SELW-1:0]  ptr;
  logic             accept;
  logic [N-1:0]     load;
  word_t [N-1:0]    slot_data;

  assign cur_sel  = mode_auto ? ptr : s;
  // Depends only on the targeted slot's state, never on in_valid.
  assign in_ready = ~out_valid[cur_sel] | out_ready[cur_sel];
  assign accept   = in_valid & in_ready;

  // Packed word array lays channel k at o[k*DW +: DW].
  assign o = slot_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= '0;
    else if (accept && mode_auto) ptr <= ptr + SELW'(1);  // N = 2**SELW, wraps 7 -> 0
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k] = accept & (cur_sel == SELW'(k));

    dmux_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .ready (out_ready[k]),
      .din   (I),
      .dout  (slot_data[k]),
      .valid (out_valid[k])
    );
  end

endmodule
